// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: command/status bundle between the arbiter and the shared I2C master
interface i2c_master_arbiter_if;
  logic       i2c_cmd_start;
  logic       i2c_cmd_read;
  logic       i2c_cmd_write;
  logic       i2c_cmd_stop;
  logic       i2c_cmd_valid;
  logic [6:0] i2c_dev_address;
  logic [7:0] i2c_data_out;
  logic       i2c_data_out_valid;
  logic       i2c_data_in_ready;
  logic       i2c_cmd_ready;
  logic       i2c_data_out_ready;
  logic       i2c_data_in_valid;
  logic       i2c_data_in_last;
  logic       i2c_missed_ack;
  logic       i2c_bus_busy;
  logic       i2c_bus_control;
  modport master (
    output i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop, i2c_cmd_valid,
           i2c_dev_address, i2c_data_out, i2c_data_out_valid, i2c_data_in_ready,
    input  i2c_cmd_ready, i2c_data_out_ready, i2c_data_in_valid, i2c_data_in_last,
           i2c_missed_ack, i2c_bus_busy, i2c_bus_control
  );
  modport slave (
    input  i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_stop, i2c_cmd_valid,
           i2c_dev_address, i2c_data_out, i2c_data_out_valid, i2c_data_in_ready,
    output i2c_cmd_ready, i2c_data_out_ready, i2c_data_in_valid, i2c_data_in_last,
           i2c_missed_ack, i2c_bus_busy, i2c_bus_control
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin owner of one I2C master shared by NUM_REQ requesters
module i2c_master_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 135000,
  parameter int FREE_CYCLES = 27000,
  parameter int CNT_W       = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_done,
  input  logic [NUM_REQ-1:0]   req_fail,
  input  logic [5*NUM_REQ-1:0] req_cmd,
  input  logic [7*NUM_REQ-1:0] req_dev_address,
  input  logic [8*NUM_REQ-1:0] req_data_out,
  input  logic [NUM_REQ-1:0]   req_data_out_valid,
  input  logic [NUM_REQ-1:0]   req_data_in_ready,
  i2c_master_arbiter_if.master bus,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   abort,
  output logic [NUM_REQ-1:0]   gnt_cmd_ready,
  output logic [NUM_REQ-1:0]   gnt_data_out_ready,
  output logic [NUM_REQ-1:0]   gnt_data_in_valid,
  output logic [NUM_REQ-1:0]   gnt_data_in_last,
  output logic [NUM_REQ-1:0]   gnt_missed_ack,
  output logic                 arb_busy,
  output logic                 arb_timeout
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;
  state_t               state, state_n;
  logic [NUM_REQ-1:0]   grant_n, abort_n;
  logic [PW-1:0]        rr_ptr, rr_n, off, win;
  logic [PW:0]          sum;
  logic [2*NUM_REQ-1:0] rot;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 tout_n, bus_free, owner_end;
  logic [4:0]           cmd;
  logic [6:0]           dev;
  logic [7:0]           dout;
  logic                 dov, dir;
  // rotate so the scan starts at rr_ptr, then map the offset back to an index
  always_comb begin
    rot = {req, req} >> rr_ptr;
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = PW'(k);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    win = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
  end
  // grant is one-hot, so an OR of the masked lanes is the mux
  always_comb begin
    cmd = '0;
    dev = '0;
    dout = '0;
    dov = 1'b0;
    dir = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) begin
      cmd  |= req_cmd[5*i +: 5];
      dev  |= req_dev_address[7*i +: 7];
      dout |= req_data_out[8*i +: 8];
      dov  |= req_data_out_valid[i];
      dir  |= req_data_in_ready[i];
    end
  end
  assign {bus.i2c_cmd_start, bus.i2c_cmd_read, bus.i2c_cmd_write, bus.i2c_cmd_stop, bus.i2c_cmd_valid} = cmd;
  assign bus.i2c_dev_address    = dev;
  assign bus.i2c_data_out       = dout;
  assign bus.i2c_data_out_valid = dov;
  assign bus.i2c_data_in_ready  = dir;
  assign gnt_cmd_ready      = grant & {NUM_REQ{bus.i2c_cmd_ready}};
  assign gnt_data_out_ready = grant & {NUM_REQ{bus.i2c_data_out_ready}};
  assign gnt_data_in_valid  = grant & {NUM_REQ{bus.i2c_data_in_valid}};
  assign gnt_data_in_last   = grant & {NUM_REQ{bus.i2c_data_in_last}};
  assign gnt_missed_ack     = grant & {NUM_REQ{bus.i2c_missed_ack}};
  assign arb_busy  = state != IDLE;
  assign bus_free  = ~bus.i2c_bus_busy & ~bus.i2c_bus_control;
  assign owner_end = |(grant & (req_done | req_fail | ~req));
  always_comb begin
    state_n = state;
    grant_n = grant;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    abort_n = '0;
    tout_n  = 1'b0;
    unique case (state)
      IDLE: if (|req) begin
        grant_n = NUM_REQ'(1) << win;
        rr_n    = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        cnt_n   = '0;
        state_n = OWN;
      end
      OWN: if (owner_end) begin
        grant_n = '0;
        cnt_n   = '0;
        state_n = RELEASE;
      end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
        grant_n = '0;
        abort_n = grant;
        tout_n  = 1'b1;
        cnt_n   = '0;
        state_n = RELEASE;
      end else cnt_n = cnt + 1'b1;
      RELEASE: if (bus_free || cnt == CNT_W'(FREE_CYCLES - 1)) begin
        tout_n  = ~bus_free;
        cnt_n   = '0;
        state_n = IDLE;
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      abort       <= '0;
      arb_timeout <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      abort       <= abort_n;
      arb_timeout <= tout_n;
      rr_ptr      <= rr_n;
      cnt         <= cnt_n;
    end
  end
endmodule
